// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - write-back/M-unit/register-file signal bundle for wb_port_arbiter
interface wb_port_arbiter_if;
   logic        P_VALID;
   logic [4:0]  P_RD;
   logic [31:0] P_DATA;
   logic        MD_VALID;
   logic        MD_READY;
   logic [4:0]  MD_RD;
   logic [31:0] MD_DATA;
   logic        ISSUE_VALID;
   logic [4:0]  ISSUE_RD;
   logic [4:0]  RS1;
   logic [4:0]  RS2;
   logic        HAZARD;
   logic [31:0] BUSY;
   logic        PIPE_STALL;
   logic        WRITE;
   logic [4:0]  INADDRESS;
   logic [31:0] IN;

   modport slave (
      input  P_VALID, P_RD, P_DATA, MD_VALID, MD_RD, MD_DATA,
      input  ISSUE_VALID, ISSUE_RD, RS1, RS2,
      output MD_READY, HAZARD, BUSY, PIPE_STALL, WRITE, INADDRESS, IN
   );

   modport master (
      output P_VALID, P_RD, P_DATA, MD_VALID, MD_RD, MD_DATA,
      output ISSUE_VALID, ISSUE_RD, RS1, RS2,
      input  MD_READY, HAZARD, BUSY, PIPE_STALL, WRITE, INADDRESS, IN
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter, pipeline priority with M-unit starvation guard
// Optional destination scoreboard enabled by defining WB_SCOREBOARD_EN.
module wb_port_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input logic              CLK,
   input logic              RESET_N,
   wb_port_arbiter_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_FORCE = 2'd2;
   localparam logic [3:0] CNT_LAST = 4'(MAX_WAIT - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [4:0]  addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        md_grant;
   logic        p_grant;

   // In FORCE the pipeline is stalled, so its request is ignored.
   assign md_grant = bus.MD_VALID & ((state_q == S_FORCE) | ~bus.P_VALID);
   assign p_grant  = bus.P_VALID & (state_q != S_FORCE);

   assign bus.MD_READY   = md_grant;
   assign bus.PIPE_STALL = (state_q == S_FORCE);
   assign bus.WRITE      = write_q;
   assign bus.INADDRESS  = addr_q;
   assign bus.IN         = data_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.MD_VALID & bus.P_VALID) begin
               state_d = (MAX_WAIT == 1) ? S_FORCE : S_WAIT;
               cnt_d   = 4'd1;
            end else begin
               cnt_d = 4'd0;
            end
         end
         S_WAIT: begin
            if (~bus.MD_VALID | md_grant) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_FORCE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Writes to x0 still consume the request but never reach the register file.
   always_comb begin
      write_d = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      if (md_grant) begin
         write_d = (bus.MD_RD != 5'd0);
         addr_d  = bus.MD_RD;
         data_d  = bus.MD_DATA;
      end else if (p_grant) begin
         write_d = (bus.P_RD != 5'd0);
         addr_d  = bus.P_RD;
         data_d  = bus.P_DATA;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= 5'd0;
         data_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

`ifdef WB_SCOREBOARD_EN
   logic [31:0] busy_q, busy_d;

   // Clear applied before set so a same-edge issue of the same register keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (md_grant)
         busy_d[bus.MD_RD] = 1'b0;
      if (bus.ISSUE_VALID & (bus.ISSUE_RD != 5'd0))
         busy_d[bus.ISSUE_RD] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         busy_q <= 32'd0;
      else
         busy_q <= busy_d;
   end

   assign bus.BUSY   = busy_q;
   assign bus.HAZARD = ((bus.RS1 != 5'd0) & busy_q[bus.RS1]) |
                       ((bus.RS2 != 5'd0) & busy_q[bus.RS2]);
`else
   wire unused_sb_inputs = ^{bus.ISSUE_VALID, bus.ISSUE_RD, bus.RS1, bus.RS2};

   assign bus.BUSY   = 32'd0;
   assign bus.HAZARD = 1'b0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;
   logic CLK = 1'b0;
   logic RESET_N;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   wb_port_arbiter_if bus ();

   wb_port_arbiter #(.MAX_WAIT(4)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic next();
      @(posedge CLK);
      #1;
   endtask

   // Every register-file write must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (RESET_N && bus.WRITE === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", bus.INADDRESS, bus.IN);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (bus.INADDRESS !== e.a || bus.IN !== e.d) begin
               bad++;
               $display("FAIL write_port: got addr=%0d data=%h expected addr=%0d data=%h",
                        bus.INADDRESS, bus.IN, e.a, e.d);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET_N         = 1'b0;
      bus.P_VALID     = 1'b0;
      bus.P_RD        = 5'd0;
      bus.P_DATA      = 32'd0;
      bus.MD_VALID    = 1'b0;
      bus.MD_RD       = 5'd0;
      bus.MD_DATA     = 32'd0;
      bus.ISSUE_VALID = 1'b0;
      bus.ISSUE_RD    = 5'd0;
      bus.RS1         = 5'd0;
      bus.RS2         = 5'd0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("reset_write", 32'(bus.WRITE), 32'd0);
      chk("reset_addr", 32'(bus.INADDRESS), 32'd0);
      chk("reset_data", bus.IN, 32'd0);
      chk("reset_stall", 32'(bus.PIPE_STALL), 32'd0);
      chk("reset_busy", bus.BUSY, 32'd0);
      next();
      RESET_N = 1'b1;

      // Pipeline-only write
      bus.P_VALID = 1'b1; bus.P_RD = 5'd5; bus.P_DATA = 32'h1234;
      push(5'd5, 32'h1234);
      @(negedge CLK);
      chk("pipe_stall", 32'(bus.PIPE_STALL), 32'd0);
      chk("pipe_md_ready", 32'(bus.MD_READY), 32'd0);
      next();
      bus.P_VALID = 1'b0;

      // M-unit with idle pipeline is accepted in the same cycle
      bus.MD_VALID = 1'b1; bus.MD_RD = 5'd7; bus.MD_DATA = 32'hDEADBEEF;
      push(5'd7, 32'hDEADBEEF);
      @(negedge CLK);
      chk("md_idle_ready", 32'(bus.MD_READY), 32'd1);
      next();
      bus.MD_VALID = 1'b0;
      next();

      // Starvation: four denied cycles, forced grant in the fifth
      bus.MD_VALID = 1'b1; bus.MD_RD = 5'd9; bus.MD_DATA = 32'hA5A50009;
      for (int i = 0; i < 4; i++) begin
         bus.P_VALID = 1'b1; bus.P_RD = 5'(10 + i); bus.P_DATA = 32'(100 + i);
         push(5'(10 + i), 32'(100 + i));
         @(negedge CLK);
         chk($sformatf("starve_ready_%0d", i), 32'(bus.MD_READY), 32'd0);
         chk($sformatf("starve_stall_%0d", i), 32'(bus.PIPE_STALL), 32'd0);
         next();
      end
      bus.P_RD = 5'd20; bus.P_DATA = 32'hBAD;
      push(5'd9, 32'hA5A50009);
      @(negedge CLK);
      chk("force_stall", 32'(bus.PIPE_STALL), 32'd1);
      chk("force_ready", 32'(bus.MD_READY), 32'd1);
      next();
      bus.MD_VALID = 1'b0; bus.P_VALID = 1'b0;
      @(negedge CLK);
      chk("after_force_stall", 32'(bus.PIPE_STALL), 32'd0);
      next();

      // x0 destinations consume the request without writing
      bus.P_VALID = 1'b1; bus.P_RD = 5'd0; bus.P_DATA = 32'h55;
      next();
      bus.P_VALID = 1'b0;
      bus.MD_VALID = 1'b1; bus.MD_RD = 5'd0; bus.MD_DATA = 32'h66;
      @(negedge CLK);
      chk("x0_md_ready", 32'(bus.MD_READY), 32'd1);
      next();
      bus.MD_VALID = 1'b0;
      next();

`ifdef WB_SCOREBOARD_EN
      bus.ISSUE_VALID = 1'b1; bus.ISSUE_RD = 5'd3;
      next();
      bus.ISSUE_VALID = 1'b0; bus.RS1 = 5'd3; bus.RS2 = 5'd0;
      @(negedge CLK);
      chk("sb_busy_set", bus.BUSY, 32'h8);
      chk("sb_hazard_rs1", 32'(bus.HAZARD), 32'd1);
      bus.RS1 = 5'd0; bus.RS2 = 5'd3;
      #1 chk("sb_hazard_rs2", 32'(bus.HAZARD), 32'd1);
      bus.RS2 = 5'd4;
      #1 chk("sb_hazard_none", 32'(bus.HAZARD), 32'd0);
      next();
      bus.MD_VALID = 1'b1; bus.MD_RD = 5'd3; bus.MD_DATA = 32'h33;
      push(5'd3, 32'h33);
      @(negedge CLK);
      chk("sb_busy_before_clear", bus.BUSY, 32'h8);
      next();
      bus.MD_VALID = 1'b0;
      @(negedge CLK);
      chk("sb_busy_cleared", bus.BUSY, 32'h0);
      next();
      bus.ISSUE_VALID = 1'b1; bus.ISSUE_RD = 5'd3;
      bus.MD_VALID = 1'b1; bus.MD_RD = 5'd3; bus.MD_DATA = 32'h34;
      push(5'd3, 32'h34);
      next();
      bus.ISSUE_VALID = 1'b0; bus.MD_VALID = 1'b0;
      @(negedge CLK);
      chk("sb_set_wins", bus.BUSY, 32'h8);
      next();
      bus.ISSUE_VALID = 1'b1; bus.ISSUE_RD = 5'd0;
      next();
      bus.ISSUE_VALID = 1'b0;
      @(negedge CLK);
      chk("sb_issue_x0", bus.BUSY, 32'h8);
      next();
`else
      bus.ISSUE_VALID = 1'b1; bus.ISSUE_RD = 5'd3;
      next();
      bus.ISSUE_VALID = 1'b0; bus.RS1 = 5'd3; bus.RS2 = 5'd3;
      @(negedge CLK);
      chk("nosb_busy", bus.BUSY, 32'h0);
      chk("nosb_hazard", 32'(bus.HAZARD), 32'd0);
      next();
`endif

      // Reset asserted while a forced grant is in progress
      bus.MD_VALID = 1'b1; bus.MD_RD = 5'd12; bus.MD_DATA = 32'hC0DE000C;
      for (int i = 0; i < 4; i++) begin
         bus.P_VALID = 1'b1; bus.P_RD = 5'(20 + i); bus.P_DATA = 32'(200 + i);
         push(5'(20 + i), 32'(200 + i));
         next();
      end
      @(negedge CLK);
      chk("pre_reset_stall", 32'(bus.PIPE_STALL), 32'd1);
      #1 RESET_N = 1'b0;
      #1;
      chk("mid_reset_stall", 32'(bus.PIPE_STALL), 32'd0);
      chk("mid_reset_write", 32'(bus.WRITE), 32'd0);
      chk("mid_reset_busy", bus.BUSY, 32'd0);
      bus.MD_VALID = 1'b0; bus.P_VALID = 1'b0;
      next();
      RESET_N = 1'b1;
      bus.MD_VALID = 1'b1; bus.P_VALID = 1'b1; bus.P_RD = 5'd1; bus.P_DATA = 32'd77;
      push(5'd1, 32'd77);
      @(negedge CLK);
      chk("post_reset_stall", 32'(bus.PIPE_STALL), 32'd0);
      chk("post_reset_ready", 32'(bus.MD_READY), 32'd0);
      next();
      bus.MD_VALID = 1'b0; bus.P_VALID = 1'b0;
      repeat (3) next();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
